// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. It samples each bit at mid-point and
//               reports a break (held-low line) only once.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int HALF_BIT     = 625,
    parameter int CNT_W        = 11
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             rx,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy,
    output logic [1:0]       state,
    output logic [3:0]       bit_count,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic             r_rx_meta;
    logic             r_rx_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_bit_count;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_armed;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_state      <= c_IDLE;
            r_count      <= '0;
            r_bit_count  <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_armed      <= 1'b1;
        end else begin
            r_rx_meta    <= rx;
            r_rx_s       <= r_rx_meta;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // After a framing error the line must go high again before
                    // a new start bit is accepted, so a break is flagged once.
                    if (!r_armed) begin
                        if (r_rx_s) begin
                            r_armed <= 1'b1;
                        end
                    end else if (!r_rx_s) begin
                        r_state     <= c_START;
                        r_count     <= '0;
                        r_bit_count <= '0;
                    end
                end
                c_START: begin
                    if (r_count == c_HALF_LAST) begin
                        r_count <= '0;
                        r_state <= r_rx_s ? c_IDLE : c_DATA;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_count == c_BIT_LAST) begin
                        r_count     <= '0;
                        r_shift     <= {r_rx_s, r_shift[7:1]};
                        r_bit_count <= r_bit_count + 4'd1;
                        if (r_bit_count == 4'd7) begin
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_STOP: begin
                    if (r_count == c_BIT_LAST) begin
                        r_count <= '0;
                        r_state <= c_IDLE;
                        if (r_rx_s) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_armed     <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != c_IDLE);
    assign state      = r_state;
    assign bit_count  = r_bit_count;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed bench for uart_rx at a reduced bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB   = 32;
    localparam int HALF  = 16;
    localparam int CNT_W = 6;
    localparam int LAT   = 2 + HALF + 9 * CPB;

    logic             clk;
    logic             nrst;
    logic             rx;
    logic [7:0]       data_out;
    logic             data_valid;
    logic             frame_err;
    logic             busy;
    logic [1:0]       state;
    logic [3:0]       bit_count;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t_start  = 0;
    int n_ferr   = 0;
    int n_both   = 0;
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .nrst       (nrst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .state      (state),
        .bit_count  (bit_count),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            rx_q.push_back(data_out);
            rx_cyc.push_back(cyc);
        end
        if (frame_err) n_ferr++;
        if (data_valid && frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_at(input int i);
        if (i < rx_q.size()) return {24'd0, rx_q[i]};
        return 32'hDEAD;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < rx_cyc.size()) return rx_cyc[i];
        return -1;
    endfunction

    task automatic clear_log();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    // Cycle-exact frame; entered and left just after a rising edge.
    task automatic tx_frame(input logic [7:0] d, input logic stop);
        rx      = 1'b0;
        t_start = cyc + 1;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic tx_async(input logic [7:0] d, input real bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = 1'b1;
        #(bit_ns);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        rx   = 1'b1;
        idle(3);
        check("rst_data_out", {24'd0, data_out}, 32'h0);
        check("rst_valid", {31'd0, data_valid}, 32'h0);
        check("rst_ferr", {31'd0, frame_err}, 32'h0);
        check("rst_state", {30'd0, state}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        nrst = 1'b1;
        idle(2 * CPB);

        // single frame with pulse timing
        clear_log();
        n_ferr = 0;
        tx_frame(8'h53, 1'b1);
        idle(CPB);
        check("single_cnt", rx_q.size(), 1);
        check("single_byte", byte_at(0), 32'h53);
        check("single_lat", cyc_at(0) - t_start, LAT);
        check("single_ferr", n_ferr, 0);
        check("single_dout", {24'd0, data_out}, 32'h53);

        // framing error then break
        clear_log();
        tx_frame(8'hFF, 1'b0);
        check("ferr_once", n_ferr, 1);
        check("ferr_dout", {24'd0, data_out}, 32'h53);
        check("ferr_novalid", rx_q.size(), 0);
        idle(5 * 10 * CPB);
        check("break_once", n_ferr, 1);
        check("break_busy", {31'd0, busy}, 32'h0);
        rx = 1'b1;
        idle(2 * CPB);
        tx_frame(8'h3C, 1'b1);
        idle(CPB);
        check("after_brk_cnt", rx_q.size(), 1);
        check("after_brk_byte", byte_at(0), 32'h3C);
        check("after_brk_ferr", n_ferr, 1);

        // back-to-back with no idle gap
        clear_log();
        tx_frame(8'h6E, 1'b1);
        tx_frame(8'h61, 1'b1);
        tx_frame(8'h70, 1'b1);
        idle(CPB);
        check("b2b_cnt", rx_q.size(), 3);
        check("b2b_b0", byte_at(0), 32'h6E);
        check("b2b_b1", byte_at(1), 32'h61);
        check("b2b_b2", byte_at(2), 32'h70);
        check("b2b_gap01", cyc_at(1) - cyc_at(0), 10 * CPB);
        check("b2b_gap12", cyc_at(2) - cyc_at(1), 10 * CPB);

        // glitch shorter than half a bit
        clear_log();
        n_ferr  = 0;
        rx      = 1'b0;
        t_start = cyc + 1;
        idle(4);
        rx = 1'b1;
        check("glitch_start", {30'd0, state}, 32'h1);
        idle(14);
        check("glitch_hold", {30'd0, state}, 32'h1);
        idle(1);
        check("glitch_idle", {30'd0, state}, 32'h0);
        idle(3 * CPB);
        check("glitch_novalid", rx_q.size(), 0);
        check("glitch_noferr", n_ferr, 0);

        // reset asserted during data bit 4
        clear_log();
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            idle(CPB);
        end
        rx = 1'b0;
        idle(CPB / 2);
        check("mid_state", {30'd0, state}, 32'h2);
        check("mid_bits", {28'd0, bit_count}, 32'h4);
        nrst = 1'b0;
        #1;
        check("mid_rst_dout", {24'd0, data_out}, 32'h0);
        check("mid_rst_state", {30'd0, state}, 32'h0);
        check("mid_rst_count", {{(32-CNT_W){1'b0}}, count}, 32'h0);
        check("mid_rst_bits", {28'd0, bit_count}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        rx = 1'b1;
        idle(5);
        nrst = 1'b1;
        idle(2 * CPB);
        tx_frame(8'hA5, 1'b1);
        idle(CPB);
        check("post_rst_cnt", rx_q.size(), 1);
        check("post_rst_byte", byte_at(0), 32'hA5);
        check("post_rst_ferr", n_ferr, 0);

        // loopback from a transmitter whose clock runs 1.5% fast
        clear_log();
        exp_q.delete();
        #3.7;
        for (int i = 0; i < 100; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            tx_async(b, CPB * 10.0 / 1.015);
        end
        idle(2 * CPB);
        check("loop_cnt", rx_q.size(), 100);
        for (int i = 0; i < 100; i++) begin
            check($sformatf("loop_b%0d", i), byte_at(i), {24'd0, exp_q[i]});
        end
        check("loop_ferr", n_ferr, 0);
        check("pulse_excl", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver, the receive-side counterpart of the team's 12 MHz / 9600-baud UART transmitter. It synchronises the asynchronous `rx` line and detects the start bit. Each bit is sampled at its mid-point using a clock-cycle counter. Each received byte is presented on `data_out` with a one-cycle `data_valid` strobe. Framing errors are flagged, and a held-low line (break) is not reported repeatedly.

## Interface
- `CLKS_PER_BIT`, 1250: clock cycles per bit (12 MHz / 9600).
- `HALF_BIT`, 625: cycles from start-detect to the start-bit mid-point sample.
- `CNT_W`, 11: width of the bit-period counter; must hold `CLKS_PER_BIT-1`.
- `clk`  in  1  system clock, 12 MHz.
- `nrst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; idle high; asynchronous to `clk`.
- `data_out`  out  8  last good byte; holds until the next good frame.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high whenever `state` is not IDLE.
- `state`  out  2  debug: IDLE=0, START=1, DATA=2, STOP=3.
- `bit_count`  out  4  debug: data bits sampled in the current frame (0..8).
- `count`  out  `CNT_W`  debug: bit-period counter.

## Operation
- **Reset values:** all outputs 0; synchroniser flops 1; internal `armed` flag 1; shift register 0.
- **Synchroniser:** two flops on `rx`, giving `rx_s`. Only `rx_s` is used by the FSM.
- **IDLE**
  - If `armed` is 0, set `armed` to 1 on `rx_s`==1.
  - If `armed`==1 and `rx_s`==0: go to START, `count`<=0, `bit_count`<=0.
- **START:** `count` increments each cycle. At `count`==`HALF_BIT-1`, sample `rx_s`:
  - `rx_s`==0: go to DATA, `count`<=0.
  - `rx_s`==1 (false start / glitch): go to IDLE. No pulse is produced.
- **DATA:** at `count`==`CLKS_PER_BIT-1`:
  - Sample the bit, LSB first: `shift`<={`rx_s`,`shift[7:1]`}, `bit_count`+1, `count`<=0.
  - Otherwise `count`+1.
  - After the 8th sample (`bit_count` becomes 8), go to STOP.
- **STOP:** at `count`==`CLKS_PER_BIT-1`, sample `rx_s`, then go to IDLE:
  - 1: `data_out`<=`shift`; `data_valid`=1 for one cycle.
  - 0: `frame_err`=1 for one cycle; `data_out` unchanged; `armed`<=0. A held-low line therefore gives exactly one `frame_err` until `rx` returns high.
- **Counter:** never exceeds `CLKS_PER_BIT-1`; no wrap past the terminal value.
- **Pulses:** `data_valid` and `frame_err` are never high in the same cycle.

## Timing
- Let Ts be the `clk` edge at which IDLE sees `rx_s`==0. Ts is 3 edges after the first edge that samples the `rx` pin low: 2 synchroniser edges, then the FSM edge.
- Start-bit sample: edge Ts+`HALF_BIT`.
- Data bit k (0..7) sample: edge Ts+`HALF_BIT`+(k+1)·`CLKS_PER_BIT`.
- Stop sample: edge Ts+`HALF_BIT`+9·`CLKS_PER_BIT` (= Ts+11875 at defaults).
  - `data_valid` / `frame_err` are high during the following cycle.
  - `state` is IDLE from that edge onward.
- **Back-to-back frames:** the FSM is in IDLE from the stop-bit mid-point. The next start edge, arriving half a bit later, is detected with no loss.
- **Reset mid-frame:** `nrst` low immediately returns every register to its reset value. The partial byte is discarded; no pulse.
- **Glitches:** a low glitch shorter than `HALF_BIT` cycles is rejected.
- **Baud tolerance:** at least ±2% mismatch between the transmitter and this receiver must still yield correct bytes.

## Test plan
- **Single frame:** drive 0x53 at 1250 clk/bit → `data_out`=0x53, `data_valid` high exactly one cycle at Ts+11876, `frame_err` stays 0.
- **Back-to-back frames:** 0x6E, 0x61, 0x70 with zero idle between frames → three `data_valid` pulses spaced 12500 cycles apart, with correct bytes in order.
- **Glitch rejection:** 300-cycle low pulse on `rx` → `state` returns to IDLE at Ts+625, with no `data_valid` and no `frame_err`.
- **Framing error and break:**
  - Stop bit driven 0 after byte 0xFF, previous byte 0x53 → one `frame_err` pulse and `data_out` stays 0x53.
  - Line held low for 5 frame times → still exactly one `frame_err`.
  - Line then released, followed by 0x3C → `data_valid`, `data_out`=0x3C.
- **Reset mid-frame:** `nrst` pulled low during data bit 4 → all outputs 0 immediately. After `nrst` release, frame 0xA5 → `data_out`=0xA5 with no spurious pulse.
- **Loopback:** drive 100 random bytes through the team's UART transmitter into `rx`, with the transmitter clock offset +1.5% → all 100 bytes received in order, `frame_err` never asserted.
